// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive side of a multiplexed 4-digit 7-segment display. It samples the
//   scanned segment/anode bus and sorts each dwell into one of four digit
//   slots. It decodes every slot back to a hex nibble and publishes a frame
//   once all four slots have been captured.
//
// Parameters
//   SETTLE   sampled cycles an must hold one valid value before capture (>=1)
//   TIMEOUT  cycles without a capture before the frame is flagged stale (>=8)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   seg[6:0]     in   segment bus {g,f,e,d,c,b,a}, active-low
//   an[3:0]      in   anode bus, active-low; an[3]=digit0 (leftmost) .. an[0]=digit3
//   digits_hex   out  {digit0,digit1,digit2,digit3}, one nibble per digit
//   blank[3:0]   out  per-digit: pattern was all-off (nibble reads 0)
//   bad[3:0]     out  per-digit: pattern not decodable (nibble reads 0)
//   frame_valid  out  one-cycle pulse when digits_hex/blank/bad update
//   stale        out  no capture for TIMEOUT cycles; clears on the next frame
//   an_err       out  one-cycle pulse: sampled an had more than one bit low
//
// Bit b of an, blank and bad, and nibble b of digits_hex, all belong to the
// same digit. The slot storage is therefore indexed directly by anode bit.
module seg_scan_decoder #(
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits_hex,
    output logic [3:0]  blank,
    output logic [3:0]  bad,
    output logic        frame_valid,
    output logic        stale,
    output logic        an_err
);

    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  SETTLE_C = CNT_W'(SETTLE);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLING, S_HELD} state_t;

    // Returns {blank, bad, nibble}.
    function automatic logic [5:0] decode_seg(input logic [6:0] p);
        case (p)
            7'h40: return 6'h00;
            7'h79: return 6'h01;
            7'h24: return 6'h02;
            7'h30: return 6'h03;
            7'h19: return 6'h04;
            7'h12: return 6'h05;
            7'h02: return 6'h06;
            7'h78: return 6'h07;
            7'h00: return 6'h08;
            7'h10: return 6'h09;
            7'h08: return 6'h0A;
            7'h03: return 6'h0B;
            7'h46: return 6'h0C;
            7'h21: return 6'h0D;
            7'h06: return 6'h0E;
            7'h0E: return 6'h0F;
            7'h7F: return 6'b10_0000;
            default: return 6'b01_0000;
        endcase
    endfunction

    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic [3:0]        r_an_prev;
    state_t            r_state;
    logic [CNT_W-1:0]  r_stable_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [3:0]        r_seen;
    logic [15:0]       r_slot_nib;
    logic [3:0]        r_slot_blank;
    logic [3:0]        r_slot_bad;
    logic [15:0]       r_digits;
    logic [3:0]        r_blank;
    logic [3:0]        r_bad;
    logic              r_frame_valid;
    logic              r_stale;
    logic              r_an_err;

    logic [3:0]        w_an_low;
    logic              w_an_none;
    logic              w_an_valid;
    logic              w_an_multi;
    logic              w_same;
    logic              w_held;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_capture;
    logic              w_complete;
    logic [5:0]        w_dec;
    logic [3:0]        w_seen_all;
    logic [15:0]       w_frame_nib;
    logic [3:0]        w_frame_blank;
    logic [3:0]        w_frame_bad;

    assign w_an_low   = ~r_an;
    assign w_an_none  = (r_an == 4'hF);
    // Exactly one bit low: non-zero and a power of two once inverted.
    assign w_an_valid = !w_an_none && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
    assign w_an_multi = !w_an_none && !w_an_valid;
    assign w_same     = (r_an == r_an_prev);
    // HELD means this dwell was already captured; wait for an to move.
    assign w_held     = (r_state == S_HELD) && w_same;
    assign w_dec      = decode_seg(r_seg);
    assign w_seen_all = r_seen | w_an_low;

    always_comb begin
        w_cnt_next = '0;
        if (w_an_valid) begin
            if (!w_same)
                w_cnt_next = CNT_W'(1);
            else if (r_stable_cnt == SETTLE_C)
                w_cnt_next = SETTLE_C;
            else
                w_cnt_next = r_stable_cnt + CNT_W'(1);
        end
    end

    assign w_capture  = w_an_valid && !w_held && (w_cnt_next == SETTLE_C);
    assign w_complete = w_capture && (w_seen_all == 4'hF);

    // The completing slot contributes its fresh decode, not its old storage.
    always_comb begin
        w_frame_nib   = r_slot_nib;
        w_frame_blank = r_slot_blank;
        w_frame_bad   = r_slot_bad;
        for (int b = 0; b < 4; b++) begin
            if (w_an_low[b]) begin
                w_frame_nib[b*4 +: 4] = w_dec[3:0];
                w_frame_blank[b]      = w_dec[5];
                w_frame_bad[b]        = w_dec[4];
            end
        end
    end

    // Slot data: validity comes from r_seen, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int b = 0; b < 4; b++) begin
                if (w_an_low[b]) begin
                    r_slot_nib[b*4 +: 4] <= w_dec[3:0];
                    r_slot_blank[b]      <= w_dec[5];
                    r_slot_bad[b]        <= w_dec[4];
                end
            end
        end
    end

    // Sampling, dwell tracking, frame assembly and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg         <= 7'h7F;
            r_an          <= 4'hF;
            r_an_prev     <= 4'hF;
            r_state       <= S_IDLE;
            r_stable_cnt  <= '0;
            r_idle_cnt    <= '0;
            r_seen        <= 4'h0;
            r_digits      <= 16'h0000;
            r_blank       <= 4'hF;
            r_bad         <= 4'h0;
            r_frame_valid <= 1'b0;
            r_stale       <= 1'b1;
            r_an_err      <= 1'b0;
        end else begin
            r_seg         <= seg;
            r_an          <= an;
            r_an_prev     <= r_an;
            r_stable_cnt  <= w_cnt_next;
            r_an_err      <= w_an_multi;
            r_frame_valid <= w_complete;

            if (!w_an_valid)
                r_state <= S_IDLE;
            else if (w_capture || w_held)
                r_state <= S_HELD;
            else
                r_state <= S_SETTLING;

            // A capture always beats the timeout in the same cycle.
            if (w_capture) begin
                r_idle_cnt <= '0;
                if (w_complete) begin
                    r_seen   <= 4'h0;
                    r_stale  <= 1'b0;
                    r_digits <= w_frame_nib;
                    r_blank  <= w_frame_blank;
                    r_bad    <= w_frame_bad;
                end else begin
                    r_seen <= w_seen_all;
                end
            end else if (r_idle_cnt == IDLE_MAX) begin
                r_stale <= 1'b1;
                r_seen  <= 4'h0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
        end
    end

    assign digits_hex  = r_digits;
    assign blank       = r_blank;
    assign bad         = r_bad;
    assign frame_valid = r_frame_valid;
    assign stale       = r_stale;
    assign an_err      = r_an_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder. u_dut1 runs with SETTLE=1 and u_dut3
// runs with SETTLE=3. Each instance has its own stimulus and reset.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic [6:0]  seg1, seg3;
    logic [3:0]  an1, an3;
    logic [15:0] dh1, dh3;
    logic [3:0]  bl1, bl3, bd1, bd3;
    logic        fv1, fv3, st1, st3, ae1, ae3;

    int checks   = 0;
    int failures = 0;

    logic [3:0] AN_ROT [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    always #5 clk = ~clk;

    seg_scan_decoder #(.SETTLE(1), .TIMEOUT(1024)) u_dut1 (
        .clk(clk), .rst(rst1), .seg(seg1), .an(an1),
        .digits_hex(dh1), .blank(bl1), .bad(bd1),
        .frame_valid(fv1), .stale(st1), .an_err(ae1)
    );

    seg_scan_decoder #(.SETTLE(3), .TIMEOUT(1024)) u_dut3 (
        .clk(clk), .rst(rst3), .seg(seg3), .an(an3),
        .digits_hex(dh3), .blank(bl3), .bad(bd3),
        .frame_valid(fv3), .stale(st3), .an_err(ae3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input pair, then let one rising edge pass and settle.
    task automatic step1(input logic [6:0] s, input logic [3:0] a);
        seg1 = s;
        an1  = a;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic [6:0] s, input logic [3:0] a);
        seg3 = s;
        an3  = a;
        @(posedge clk);
        #1;
    endtask

    // One-cycle-per-digit rotation; fvs[i] is frame_valid after step i.
    task automatic scan1(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         output logic [3:0] fvs);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            step1(s[i], AN_ROT[i]);
            fvs[i] = fv1;
        end
    endtask

    // Four-cycle dwell on one digit for the SETTLE=3 instance.
    task automatic dwell3(input logic [6:0] s, input logic [3:0] a);
        for (int i = 0; i < 4; i++) step3(s, a);
    endtask

    initial begin
        logic [3:0] fvs;
        logic       any_fv;
        logic       any_st;

        rst1 = 1'b1; rst3 = 1'b1;
        seg1 = 7'h7F; an1 = 4'hF;
        seg3 = 7'h7F; an3 = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_digits", dh1, 16'h0000);
        chk("rst_blank", bl1, 4'hF);
        chk("rst_bad", bd1, 4'h0);
        chk("rst_fv", fv1, 1'b0);
        chk("rst_stale", st1, 1'b1);
        chk("rst_an_err", ae1, 1'b0);
        chk("rst3_stale", st3, 1'b1);
        chk("rst3_blank", bl3, 4'hF);
        rst1 = 1'b0; rst3 = 1'b0;

        // Fast scan 1,2,3,4: first frame completes on the next rotation's first edge.
        scan1(7'h79, 7'h24, 7'h30, 7'h19, fvs);
        chk("t1_cold_fv", fvs, 4'b0000);
        scan1(7'h79, 7'h24, 7'h30, 7'h19, fvs);
        chk("t1_fv_pattern", fvs, 4'b0001);
        chk("t1_digits", dh1, 16'h1234);
        chk("t1_blank", bl1, 4'h0);
        chk("t1_bad", bd1, 4'h0);
        chk("t1_stale", st1, 1'b0);
        scan1(7'h79, 7'h24, 7'h30, 7'h19, fvs);
        chk("t1_fv_again", fvs, 4'b0001);

        // Blank and undecodable patterns.
        scan1(7'h79, 7'h7F, 7'h7E, 7'h19, fvs);
        chk("t2_fv_first", fvs, 4'b0001);
        scan1(7'h79, 7'h7F, 7'h7E, 7'h19, fvs);
        chk("t2_fv", fvs, 4'b0001);
        chk("t2_digits", dh1, 16'h1004);
        chk("t2_blank", bl1, 4'b0100);
        chk("t2_bad", bd1, 4'b0010);

        // Multi-low anode glitch mid-scan.
        step1(7'h12, 4'b0111);
        chk("t4_prev_frame_fv", fv1, 1'b1);
        step1(7'h02, 4'b1011);
        step1(7'h7F, 4'b0011);
        step1(7'h78, 4'b1101);
        chk("t4_an_err_pulse", ae1, 1'b1);
        chk("t4_no_fv", fv1, 1'b0);
        step1(7'h00, 4'b1110);
        chk("t4_an_err_clear", ae1, 1'b0);
        step1(7'h7F, 4'b1111);
        chk("t4_fv", fv1, 1'b1);
        chk("t4_digits", dh1, 16'h5678);
        chk("t4_bad", bd1, 4'h0);
        step1(7'h7F, 4'b1111);
        chk("t4_fv_one_cycle", fv1, 1'b0);

        // Digit0 captured twice; the later value wins.
        step1(7'h40, 4'b0111);
        step1(7'h7F, 4'b1111);
        step1(7'h08, 4'b0111);
        step1(7'h24, 4'b1011);
        step1(7'h30, 4'b1101);
        step1(7'h19, 4'b1110);
        chk("t6_no_early_fv", fv1, 1'b0);
        step1(7'h7F, 4'b1111);
        chk("t6_fv", fv1, 1'b1);
        chk("t6_digits", dh1, 16'hA234);

        // Reset after two captures discards the partial frame.
        step1(7'h12, 4'b0111);
        step1(7'h02, 4'b1011);
        step1(7'h7F, 4'b1111);
        rst1 = 1'b1;
        #1;
        chk("t5_rst_digits", dh1, 16'h0000);
        chk("t5_rst_blank", bl1, 4'hF);
        chk("t5_rst_stale", st1, 1'b1);
        chk("t5_rst_fv", fv1, 1'b0);
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        step1(7'h30, 4'b1101);
        step1(7'h19, 4'b1110);
        step1(7'h7F, 4'b1111);
        chk("t5_no_fv_two_slots", fv1, 1'b0);
        step1(7'h79, 4'b0111);
        step1(7'h24, 4'b1011);
        step1(7'h7F, 4'b1111);
        chk("t5_fv", fv1, 1'b1);
        chk("t5_digits", dh1, 16'h1234);
        chk("t5_stale", st1, 1'b0);

        // SETTLE=3: four-cycle dwells build a frame.
        dwell3(7'h79, 4'b0111);
        dwell3(7'h24, 4'b1011);
        dwell3(7'h30, 4'b1101);
        chk("t3_no_early_fv", fv3, 1'b0);
        dwell3(7'h19, 4'b1110);
        chk("t3_fv", fv3, 1'b1);
        chk("t3_digits", dh3, 16'h1234);
        chk("t3_stale_clear", st3, 1'b0);

        // One-cycle dwells never settle; stale rises 1024 edges after the last capture.
        any_fv = 1'b0;
        any_st = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            step3(7'h79, AN_ROT[i % 4]);
            any_fv |= fv3;
            any_st |= st3;
        end
        chk("t3_fast_no_fv", any_fv, 1'b0);
        chk("t3_stale_not_yet", any_st, 1'b0);
        step3(7'h79, AN_ROT[3]);
        chk("t3_stale_rise", st3, 1'b1);
        chk("t3_digits_kept", dh3, 16'h1234);

        step3(7'h7F, 4'b1111);
        dwell3(7'h0E, 4'b0111);
        dwell3(7'h06, 4'b1011);
        dwell3(7'h21, 4'b1101);
        chk("t3_stale_holds", st3, 1'b1);
        dwell3(7'h46, 4'b1110);
        chk("t3_fv2", fv3, 1'b1);
        chk("t3_digits2", dh3, 16'hFEDC);
        chk("t3_stale_clear2", st3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
